// File: rtl/ins_fetch.sv
// Instruction fetch stage: direct-mapped instruction cache in front of a req/ack instruction memory.
// Optional hit/miss statistics counters are built when FETCH_STATS_EN is defined.
module ins_fetch #(
    parameter int ENTRIES = 4,
    parameter int ADDR_W  = 8,
    parameter int INS_W   = 8
) (
    input  logic              clk,
    input  logic              CLB,
    input  logic [ADDR_W-1:0] pc,
    output logic [INS_W-1:0]  input_ins,
    output logic              ins_valid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [INS_W-1:0]  mem_data,
    output logic [7:0]        hit_count,
    output logic [7:0]        miss_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W;

    typedef enum logic {LOOKUP, FILL} state_t;

    state_t state, state_nx;

    logic [ENTRIES-1:0] line_valid;
    logic [TAG_W-1:0]   line_tag  [ENTRIES];
    logic [INS_W-1:0]   line_data [ENTRIES];

    logic [IDX_W-1:0] idx, fill_idx;
    logic [TAG_W-1:0] tag, fill_tag;
    logic             hit, do_hit, do_miss, do_fill;

    assign idx      = pc[IDX_W-1:0];
    assign tag      = pc[ADDR_W-1:IDX_W];
    assign fill_idx = mem_addr[IDX_W-1:0];
    assign fill_tag = mem_addr[ADDR_W-1:IDX_W];
    assign hit      = line_valid[idx] && (line_tag[idx] == tag);

    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) state <= LOOKUP;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        do_hit   = 1'b0;
        do_miss  = 1'b0;
        do_fill  = 1'b0;
        case (state)
            LOOKUP: begin
                if (hit) begin
                    do_hit = 1'b1;
                end else begin
                    do_miss  = 1'b1;
                    state_nx = FILL;
                end
            end
            FILL: begin
                if (mem_req && mem_ack) begin
                    do_fill  = 1'b1;
                    state_nx = LOOKUP;
                end
            end
            default: state_nx = LOOKUP;
        endcase
    end

    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            input_ins  <= '0;
            ins_valid  <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            line_valid <= '0;
        end else begin
            if (do_hit) begin
                input_ins <= line_data[idx];
                ins_valid <= 1'b1;
            end
            if (do_miss) begin
                ins_valid <= 1'b0;
                mem_addr  <= pc;
                mem_req   <= 1'b1;
            end
            if (do_fill) begin
                line_valid[fill_idx] <= 1'b1;
                input_ins            <= mem_data;
                ins_valid            <= 1'b1;
                mem_req              <= 1'b0;
            end
        end
    end

    // Tag/data need no reset: they are qualified by line_valid.
    always_ff @(posedge clk) begin
        if (do_fill) begin
            line_tag[fill_idx]  <= fill_tag;
            line_data[fill_idx] <= mem_data;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (do_hit && hit_count != '1)   hit_count  <= hit_count + 8'd1;
            if (do_miss && miss_count != '1) miss_count <= miss_count + 8'd1;
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: doc/ins_fetch.md
# ins_fetch

Instruction fetch stage sitting directly upstream of `core`: takes the core's `pc`, returns the 8-bit instruction (`op` = [7:4], `imm` = [3:0]) on `input_ins`, and replaces the bench-side instruction array in the synthesizable top level. It holds a small direct-mapped instruction cache in front of a variable-latency instruction memory reached through a req/ack handshake. `ins_valid` tells the core when `input_ins` is usable; the core holds `pc` while it is low.

## Interface
- `ENTRIES`, 4: cache lines, one instruction each; power of two, 2..16.
- `ADDR_W`, 8: pc/memory address width.
- `INS_W`, 8: instruction width.

- `clk`  in  1  rising-edge clock.
- `CLB`  in  1  reset; asynchronous, active-low.
- `pc`  in  ADDR_W  fetch address from core.
- `input_ins`  out  INS_W  instruction for the last accepted pc; registered.
- `ins_valid`  out  1  `input_ins` is valid for the pc presented on the previous edge.
- `mem_req`  out  1  memory read request; registered.
- `mem_addr`  out  ADDR_W  memory read address; registered; stable while `mem_req`=1.
- `mem_ack`  in  1  memory returns data this cycle.
- `mem_data`  in  INS_W  read data; sampled only with `mem_ack`.
- `hit_count`  out  8  cache hit counter (see Configuration).
- `miss_count`  out  8  cache miss counter (see Configuration).

## Operation
- Index = `pc[log2(ENTRIES)-1:0]`; tag = remaining upper pc bits. Per line: valid bit, tag, instruction.
- States:
  - LOOKUP: compare `pc` at each edge. Hit -> `input_ins` <= line data, `ins_valid` <= 1, stay. Miss -> `ins_valid` <= 0, `mem_addr` <= pc, `mem_req` <= 1, go FILL.
  - FILL: hold `mem_req`/`mem_addr`. Transfer occurs at an edge where `mem_req`=1 and `mem_ack`=1: write line (valid, tag, data), `input_ins` <= `mem_data`, `ins_valid` <= 1, `mem_req` <= 0, go LOOKUP.
- The miss address is captured at the miss edge; `pc` changes during FILL are ignored. The fill completes for the captured address, and the next LOOKUP re-evaluates the current `pc`.
- `mem_ack` with `mem_req`=0 is ignored: no write, no state change.
- Conflict misses overwrite the line unconditionally; there is no replacement policy.
- Reset values: `input_ins`=0, `ins_valid`=0, `mem_req`=0, `mem_addr`=0, all line valid bits 0, counters 0, state LOOKUP.
- Reset asserted mid-FILL: `mem_req` drops asynchronously and the pending fill is discarded; no line is written.

## Timing
- Hit latency: 1 cycle. A `pc` sampled at edge N gives `input_ins`/`ins_valid` at edge N. This matches the core's one-cycle pc->instruction pipe.
- Miss: `mem_req` rises at edge N. With ack at edge N+k, data is valid at edge N+k with `ins_valid`=1 and `mem_req`=0. The next lookup is at edge N+k+1.
- Minimum miss penalty is 1 cycle (ack already high when `mem_req` rises).
- No combinational path from `pc` or `mem_ack` to any output.

## Configuration
- `FETCH_STATS_EN` defined: `hit_count` increments on each LOOKUP hit and `miss_count` on each LOOKUP miss. Both saturate at 255 and clear on reset.
- Not defined: counters not built; `hit_count` and `miss_count` tied to 8'h00.

## Test plan
- Reset: hold `CLB`=0 with `pc`=0x00 and `mem_ack`=1 -> all outputs 0, no `mem_req`.
- Cold miss: `pc`=0x00, ack 3 cycles after `mem_req` rises with `mem_data`=0x5A -> `mem_req` high for 3 cycles at `mem_addr`=0x00, then `input_ins`=0x5A with `ins_valid`=1 at the ack edge.
- Hit: re-present `pc`=0x00 -> `input_ins`=0x5A, `ins_valid`=1 after 1 cycle, `mem_req` stays 0.
- Conflict (ENTRIES=4): `pc`=0x04, fill 0x33 -> `input_ins`=0x33. Then `pc`=0x00 -> miss again, `mem_addr`=0x00.
- Reset mid-fill: drop `CLB` while `mem_req`=1 -> `mem_req`=0 immediately. After release, `pc`=0x00 misses.
- Stats (`FETCH_STATS_EN`): pc sequence 0x00,0x00,0x01,0x01 with 1-cycle fills -> `hit_count`=2, `miss_count`=2. Without the macro, both read 0.
